// File: rtl/gfx_pkg.sv
// Shared types and default 640x480 timing for the VGA framebuffer.
package gfx_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef enum logic {
        MODE_NATIVE = 1'b0,
        MODE_DOUBLE = 1'b1
    } display_mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_ADDR_W   = 20;

endpackage

// File: rtl/vga_timing.sv
// Raster counters, raw sync levels, blanking markers and the
// per-cycle slot type (display fetch or CPU slot).
module vga_timing
    import gfx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_double,
    output logic [HW-1:0] o_h,
    output logic          o_v_odd,
    output logic          o_active,
    output logic          o_fetch,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_vblank,
    output logic          o_frame_tick,
    output logic          o_line_end,
    output logic          o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_v_act;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_v_act  = (r_v < V_ACT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : r_v + 1'b1;
            end
        end
    end

    assign o_h          = r_h;
    assign o_v_odd      = r_v[0];
    assign o_active     = (r_h < H_ACT) && w_v_act;
    // Doubled mode leaves odd columns free for the CPU.
    assign o_fetch      = o_active && !(i_double && r_h[0]);
    assign o_hs         = (r_h >= H_SS && r_h < H_SE) ? SYNC_POL : !SYNC_POL;
    assign o_vs         = (r_v >= V_SS && r_v < V_SE) ? SYNC_POL : !SYNC_POL;
    assign o_vblank     = !w_v_act;
    assign o_frame_tick = (r_h == '0) && (r_v == V_ACT);
    assign o_line_end   = (r_h == H_ALAST) && w_v_act;
    assign o_frame_end  = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/vga_framebuffer.sv
// VGA scan-out from a single-port external VRAM shared with a CPU
// write port, with a frame-latched 2x2 pixel-doubling mode.
module vga_framebuffer
    import gfx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    output logic [ADDR_W-1:0] vram_address,
    output logic              vram_we,
    output logic [7:0]        vram_w_data,
    input  logic [7:0]        vram_r_data,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              h_sync,
    output logic              v_sync,
    output logic              video_enable,
    output logic              vblank,
    output logic              frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [ADDR_W-1:0] LINE_NAT = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_DBL = ADDR_W'(H_ACTIVE / 2);

    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
    end

    display_mode_e     r_mode;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [HW-1:0]     w_h;
    logic              w_v_odd;
    logic              w_active;
    logic              w_fetch;
    logic              w_hs;
    logic              w_vs;
    logic              w_line_end;
    logic              w_frame_end;
    logic              w_double;
    logic              w_xfer;
    logic              r_en1;
    logic              r_en2;
    logic              r_fetch1;
    logic              r_hs1;
    logic              r_hs2;
    logic              r_vs1;
    logic              r_vs2;
    rgb332_t           r_pix;

    assign w_double = (r_mode == MODE_DOUBLE);

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .i_double     (w_double),
        .o_h          (w_h),
        .o_v_odd      (w_v_odd),
        .o_active     (w_active),
        .o_fetch      (w_fetch),
        .o_hs         (w_hs),
        .o_vs         (w_vs),
        .o_vblank     (vblank),
        .o_frame_tick (frame_tick),
        .o_line_end   (w_line_end),
        .o_frame_end  (w_frame_end)
    );

    assign cpu_ready    = !w_fetch;
    assign w_xfer       = cpu_valid && cpu_ready;
    assign w_fetch_addr = r_line_base + ADDR_W'(w_double ? (w_h >> 1) : w_h);
    assign vram_address = w_xfer ? cpu_addr : w_fetch_addr;
    assign vram_we      = w_xfer;
    assign vram_w_data  = w_xfer ? cpu_data : '0;

    // Doubled mode advances the base only after odd lines so pairs repeat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= MODE_NATIVE;
            r_line_base <= '0;
        end else if (w_frame_end) begin
            r_mode      <= display_mode_e'(mode);
            r_line_base <= '0;
        end else if (w_line_end && !w_double) begin
            r_line_base <= r_line_base + LINE_NAT;
        end else if (w_line_end && w_v_odd) begin
            r_line_base <= r_line_base + LINE_DBL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en1    <= 1'b0;
            r_en2    <= 1'b0;
            r_fetch1 <= 1'b0;
            r_hs1    <= !SYNC_POL;
            r_hs2    <= !SYNC_POL;
            r_vs1    <= !SYNC_POL;
            r_vs2    <= !SYNC_POL;
            r_pix    <= '0;
        end else begin
            r_en1    <= w_active;
            r_en2    <= r_en1;
            r_fetch1 <= w_fetch;
            r_hs1    <= w_hs;
            r_hs2    <= r_hs1;
            r_vs1    <= w_vs;
            r_vs2    <= r_vs1;
            // Non-fetch active cycles repeat the last pixel.
            if (!r_en1) begin
                r_pix <= '0;
            end else if (r_fetch1) begin
                r_pix <= rgb332_t'(vram_r_data);
            end
        end
    end

    assign red          = r_pix.r;
    assign green        = r_pix.g;
    assign blue         = r_pix.b;
    assign h_sync       = r_hs2;
    assign v_sync       = r_vs2;
    assign video_enable = r_en2;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed-plus-random bench for vga_framebuffer on a tiny 8x4 raster,
// checked against a raster-arithmetic reference model.
module tb_vga_framebuffer;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int AW  = 8;

    logic          clk;
    logic          rst;
    logic          mode;
    logic          cpu_valid;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic [AW-1:0] vram_address;
    logic          vram_we;
    logic [7:0]    vram_w_data;
    logic [7:0]    vram_r_data;
    logic [2:0]    red;
    logic [2:0]    green;
    logic [1:0]    blue;
    logic          h_sync;
    logic          v_sync;
    logic          video_enable;
    logic          vblank;
    logic          frame_tick;

    vga_framebuffer #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .ADDR_W   (AW),
        .SYNC_POL (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .vram_address (vram_address),
        .vram_we      (vram_we),
        .vram_w_data  (vram_w_data),
        .vram_r_data  (vram_r_data),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .video_enable (video_enable),
        .vblank       (vblank),
        .frame_tick   (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM: unwritten locations read back their own address.
    logic [7:0] vmem [256];
    bit         written [256];
    always @(posedge clk) begin
        if (vram_we) begin
            vmem[vram_address]    <= vram_w_data;
            written[vram_address] <= 1'b1;
        end
        vram_r_data <= written[vram_address] ? vmem[vram_address] : vram_address;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n;
    int         fm;
    bit         xfer_done;
    bit         rand_on;
    logic [7:0] ref_mem [256];
    logic [7:0] cur_px;
    logic       e_en [2];
    logic       e_hs [2];
    logic       e_vs [2];
    logic [7:0] e_px [2];
    int         tick_cnt = 0;
    int         en_cnt = 0;
    int         hs_lo = 0;
    int         vs_lo = 0;

    function automatic int cur_h();
        return n % HT;
    endfunction

    function automatic int cur_v();
        return (n / HT) % VT;
    endfunction

    function automatic bit act_f(int h, int v);
        return h < HA && v < VA;
    endfunction

    function automatic bit fetch_f(int h, int v, int m);
        return act_f(h, v) && (m == 0 || h % 2 == 0);
    endfunction

    function automatic int faddr_f(int h, int v, int m);
        return m != 0 ? (v / 2) * (HA / 2) + h / 2 : v * HA + h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        fm = 0;
        xfer_done = 1'b0;
        cur_px = '0;
        for (int i = 0; i < 2; i++) begin
            e_en[i] = 1'b0;
            e_hs[i] = 1'b1;
            e_vs[i] = 1'b1;
            e_px[i] = '0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_h_sync"}, h_sync, 1);
        chk({tag, "_v_sync"}, v_sync, 1);
        chk({tag, "_video_enable"}, video_enable, 0);
        chk({tag, "_rgb"}, {red, green, blue}, 0);
        chk({tag, "_vram_we"}, vram_we, 0);
        chk({tag, "_cpu_ready"}, cpu_ready, 0);
        chk({tag, "_vblank"}, vblank, 0);
        chk({tag, "_frame_tick"}, frame_tick, 0);
    endtask

    task automatic check();
        int h, v;
        bit f, we;
        h = cur_h();
        v = cur_v();
        f = fetch_f(h, v, fm);
        we = cpu_valid && !f;
        chk("cpu_ready", cpu_ready, !f);
        chk("vram_we", vram_we, we);
        if (we) begin
            chk("cpu_addr", vram_address, cpu_addr);
            chk("cpu_wdata", vram_w_data, cpu_data);
        end else if (f) begin
            chk("fetch_addr", vram_address, faddr_f(h, v, fm));
        end
        chk("vblank", vblank, v >= VA);
        chk("frame_tick", frame_tick, h == 0 && v == VA);
        chk("h_sync", h_sync, e_hs[1]);
        chk("v_sync", v_sync, e_vs[1]);
        chk("video_enable", video_enable, e_en[1]);
        chk("rgb", {red, green, blue}, e_px[1]);
        tick_cnt += int'(frame_tick);
        en_cnt   += int'(video_enable);
        hs_lo    += int'(!h_sync);
        vs_lo    += int'(!v_sync);
    endtask

    task automatic advance();
        int h, v;
        bit f;
        h = cur_h();
        v = cur_v();
        f = fetch_f(h, v, fm);
        xfer_done = cpu_valid && !f;
        if (xfer_done) ref_mem[cpu_addr] = cpu_data;
        if (f) cur_px = ref_mem[faddr_f(h, v, fm)];
        e_en[1] = e_en[0];
        e_hs[1] = e_hs[0];
        e_vs[1] = e_vs[0];
        e_px[1] = e_px[0];
        e_en[0] = act_f(h, v);
        e_hs[0] = !(h >= HA + HFP && h < HA + HFP + HS);
        e_vs[0] = !(v >= VA + VFP && v < VA + VFP + VS);
        e_px[0] = act_f(h, v) ? cur_px : 8'h00;
        if (h == HT - 1 && v == VT - 1) fm = int'(mode);
        n++;
    endtask

    task automatic cyc();
        if (cpu_valid && xfer_done) cpu_valid = 1'b0;
        if (rand_on && !cpu_valid && $urandom_range(3, 0) == 0) begin
            cpu_valid = 1'b1;
            cpu_addr  = AW'($urandom_range(31, 0));
            cpu_data  = 8'($urandom_range(255, 0));
        end
        #1;
        check();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic run_to(input int th, input int tv);
        for (int i = 0; i < 400 && !(cur_h() == th && cur_v() == tv); i++) begin
            cyc();
        end
        chk("run_to_position", cur_h() * 256 + cur_v(), th * 256 + tv);
    endtask

    initial begin
        rst = 1'b0;
        mode = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        rand_on = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        chk_reset("reset");

        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Three native frames, CPU idle.
        repeat (3 * HT * VT) cyc();
        chk("frame_tick_count", tick_cnt, 3);
        chk("video_enable_count", en_cnt, 3 * HA * VA);
        chk("h_sync_low_count", hs_lo, 3 * VT * HS);
        chk("v_sync_low_count", vs_lo, 3 * VS * HT);

        // CPU write stalls through the active part of line 0.
        cpu_valid = 1'b1;
        cpu_addr  = 8'd5;
        cpu_data  = 8'hE3;
        for (int i = 0; i < HA; i++) begin
            #1;
            chk("stall_ready_low", cpu_ready, 0);
            cyc();
        end
        #1;
        chk("stall_we", vram_we, 1);
        chk("stall_addr", vram_address, 5);
        chk("stall_data", vram_w_data, 8'hE3);
        cyc();
        run_to(0, 0);

        // Random writes, then doubled mode requested mid-frame.
        rand_on = 1'b1;
        repeat (HT * VT / 2) cyc();
        mode = 1'b1;
        run_to(0, 0);
        rand_on = 1'b0;
        run_to(2, 1);
        cpu_valid = 1'b1;
        cpu_addr  = 8'd1;
        cpu_data  = 8'h5A;
        #1;
        chk("dbl_even_ready", cpu_ready, 0);
        cyc();
        #1;
        chk("dbl_odd_we", vram_we, 1);
        chk("dbl_odd_addr", vram_address, 1);
        cyc();
        rand_on = 1'b1;
        run_to(0, 0);
        repeat (HT * VT) cyc();

        // Asynchronous reset in the middle of an active line.
        run_to(5, 2);
        rand_on = 1'b0;
        #3;
        rst = 1'b0;
        cpu_valid = 1'b1;
        cpu_addr  = 8'd7;
        cpu_data  = 8'h11;
        #1;
        chk_reset("midreset");
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("post_reset_addr", vram_address, 0);
        cyc();
        #1;
        chk("post_reset_native", cpu_ready, 0);
        cyc();
        rand_on = 1'b1;
        repeat (HT * VT + HT * VT / 2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer.md
Name: vga_framebuffer

Overview:
- Parametrised successor to the fixed-mode graphics card: VGA timing, VRAM scan-out and RGB332 pixel output in one block.
- Adds programmable timing and a frame-latched display mode: 0 = native resolution, 1 = 2x2 pixel doubling.
- Adds a CPU write port that shares the single VRAM port with scan-out through slot arbitration.
- Sits between the system bus/CPU and the VGA connector; VRAM stays external.

Parameters:
- H_ACTIVE, 640, visible pixels per line (even)
- H_FP, 16, horizontal front porch cycles
- H_SYNC, 96, horizontal sync pulse cycles
- H_BP, 48, horizontal back porch cycles
- V_ACTIVE, 480, visible lines (even)
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vertical sync pulse lines
- V_BP, 33, vertical back porch lines
- ADDR_W, 20, VRAM address width; requires H_ACTIVE*V_ACTIVE <= 2**ADDR_W (elaboration assertion)
- SYNC_POL, 0, active level of h_sync/v_sync

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- mode  in  1  requested mode, sampled once per frame
- cpu_valid  in  1  CPU write request
- cpu_ready  out  1  write slot available this cycle
- cpu_addr  in  ADDR_W  write address
- cpu_data  in  8  write data (RGB332)
- vram_address  out  ADDR_W  VRAM address
- vram_we  out  1  VRAM write enable
- vram_w_data  out  8  VRAM write data
- vram_r_data  in  8  VRAM read data, valid 1 cycle after address
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- video_enable  out  1  pixel in visible area
- vblank  out  1  high while v_count >= V_ACTIVE (undelayed)
- frame_tick  out  1  one-cycle pulse at h=0, v=V_ACTIVE

Behaviour:
- Reset values: counters 0, mode_q 0, line_base 0, red/green/blue 0, video_enable 0, h_sync/v_sync = !SYNC_POL, vram_we 0, cpu_ready 0, vblank 0, frame_tick 0.
- Counters: h_count 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters.
  - At wrap, v_count advances and wraps at V_TOTAL.
  - Sync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); v_sync likewise on lines.
- Mode latch: mode_q <= mode only at h=H_TOTAL-1, v=V_TOTAL-1. A mid-frame mode change has no effect until the next frame.
- Fetch slots: a cycle is a display fetch when h<H_ACTIVE and v<V_ACTIVE, and additionally, when mode_q=1, h is even. Every other cycle is a CPU slot.
- Fetch address, computed from a running line_base with no multiplier:
  - mode 0: line_base + h.
  - mode 1: line_base + (h>>1).
  - At end of each active line, line_base += H_ACTIVE in mode 0.
  - In mode 1, line_base += H_ACTIVE/2 only after odd lines, so even/odd line pairs repeat.
  - line_base clears at frame start.
- CPU port:
  - cpu_ready = 1 exactly in CPU slots; it is derived from counters, never from cpu_valid.
  - Transfer occurs on cpu_valid && cpu_ready. That cycle drives vram_address=cpu_addr, vram_we=1, vram_w_data=cpu_data.
  - Otherwise vram_we=0.
  - In mode 0, writes are possible only in blanking. In mode 1, odd active pixels also offer a slot.
  - The CPU must hold valid/addr/data stable until the transfer.
- Pixel pipeline, latency 2:
  - Cycle 0: address out.
  - Cycle 1: vram_r_data is captured into a pixel register.
    - In mode 1, odd-h cycles hold the previous value (pixel repeat).
  - Cycle 2: red/green/blue registered from it (bits 7:5, 4:2, 1:0).
  - h_sync, v_sync and video_enable are delayed 2 cycles to stay aligned.
  - RGB is forced to 0 when the delayed enable is 0.
- frame_tick and vblank are not delayed.
- Reset mid-frame: everything returns immediately to reset values. Counting restarts at h=0, v=0 on the first clock after release.

Decomposition:
- gfx_pkg holds:
  - the rgb332_t typedef (packed r[2:0], g[2:0], b[1:0]);
  - the display_mode_e enum (MODE_NATIVE, MODE_DOUBLE);
  - default 640x480 timing localparams.
- One sub-module, vga_timing: counters, sync generation, active/vblank/frame_tick and the slot-type signal.
- The top level holds mode_q, line_base, the arbitration mux and the pixel pipeline.

Test Plan:
- Test parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0.
- Timing: mode=0, run 3 frames.
  - h_sync low for exactly 2 of every 14 cycles; v_sync low 1 line of 7.
  - frame_tick period 98 cycles.
  - video_enable high 32 cycles/frame, lagging h_count<8 by 2 cycles.
- Native scan: VRAM model returns address[7:0] as data.
  - vram_address sequence per frame is 0..31.
  - RGB equals that sequence 2 cycles later.
- Doubled mode: set mode=1 mid-frame.
  - The current frame is unchanged.
  - The next frame fetches on even h only, with per-line addresses 0,1,2,3 / 0,1,2,3 / 4,5,6,7 / 4,5,6,7.
  - Each pixel is output twice.
- CPU stall: mode 0, cpu_valid=1 with addr=5, data=8'hE3 asserted at h=0, v=0.
  - cpu_ready is held low for the 8 active cycles.
  - The write occurs at h=8: vram_we=1, vram_address=5, vram_w_data=E3.
  - Scan addresses are undisturbed.
- CPU in doubled mode: valid asserted at even active h. Transfer completes on the next odd h and does not disturb the repeated pixel value.
- Reset mid-frame: assert rst=0 at h=5, v=2.
  - All outputs take reset values asynchronously, before the next clock edge.
  - After release, the first fetch address is 0 and mode_q=0.
